pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/mips_pkg.sv | 12 +
 rtl/sl2.sv | 9 +
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: the fetch FSM state type and the PC step.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/sl2.sv
// Shift-left-by-two: turns a word offset into a byte offset. Bits shifted out are dropped.
module sl2 (
  input  logic [31:0] i_a,
  output logic [31:0] o_y
);

  assign o_y = i_a << 2;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: next-PC selection (jr > j > taken beq > +4), fetch stall,
// BOOT/RUN/HALT control and saturating branch statistics.
// Optional feature: define PC_MISALIGN_TRAP_EN to halt on a jr to a non-word-aligned target.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             branch_d,
  input  logic             eq_d,
  input  logic             jump_d,
  input  logic             jr_d,
  input  logic [31:0]      pcplus4_d,
  input  logic [31:0]      signimm_d,
  input  logic [31:0]      rs_d,
  input  logic [25:0]      instr_idx_d,
  output logic [31:0]      pc_f,
  output logic [31:0]      pcplus4_f,
  output logic             flush_d,
  output logic             fetch_valid,
  output logic             halt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pc_state_t        r_state;
  logic             r_fetch_valid;
  logic             r_halt;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [31:0] w_imm_sl2;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_jr_tgt;
  logic [31:0] w_target;
  logic        w_dec_go;
  logic        w_taken;
  logic        w_redirect;
  logic        w_trap;

  sl2 u_sl2 (
    .i_a (signimm_d),
    .o_y (w_imm_sl2)
  );

  assign w_branch_tgt = pcplus4_d + w_imm_sl2;
  assign w_jump_tgt   = {pcplus4_d[31:28], instr_idx_d, 2'b00};

  // Decode may act only while running and not stalled.
  assign w_dec_go   = (r_state == RUN) && !stall_d;
  assign w_taken    = w_dec_go && branch_d && eq_d && !jr_d && !jump_d;
  assign w_redirect = w_dec_go && (jr_d || jump_d || (branch_d && eq_d));

`ifdef PC_MISALIGN_TRAP_EN
  assign w_jr_tgt = rs_d;
  assign w_trap   = w_dec_go && jr_d && (rs_d[1:0] != 2'b00);
`else
  assign w_jr_tgt = rs_d & ~32'd3;
  assign w_trap   = 1'b0;
`endif

  // Redirect target by priority: jr, then j, then taken beq.
  always_comb begin
    // NOTE: default assignment first so every path drives w_target and no latch is inferred.
    w_target = w_branch_tgt;
    if (jr_d)        w_target = w_jr_tgt;
    else if (jump_d) w_target = w_jump_tgt;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BOOT;
      r_fetch_valid <= 1'b0;
      r_halt        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      case (r_state)
        BOOT: begin
          r_state       <= RUN;
          r_fetch_valid <= 1'b1;
          r_halt        <= 1'b0;
        end
        RUN: begin
          if (w_trap) begin
            r_state       <= HALT;
            r_fetch_valid <= 1'b0;
            r_halt        <= 1'b1;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state       <= BOOT;
          r_fetch_valid <= 1'b0;
          r_halt        <= 1'b0;
        end
      endcase
    end
  end

  // Fetch PC: redirect beats the fetch stall; a trapping jr leaves the PC alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_redirect && !w_trap) begin
      r_pc <= w_target;
    end else if ((r_state == RUN) && !w_redirect && !stall_f) begin
      r_pc <= r_pc + PC_INCR;
    end
  end

  // Saturating branch statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_dec_go && branch_d && (r_branch_cnt != CNT_MAX))
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      if (w_taken && (r_taken_cnt != CNT_MAX))
        r_taken_cnt <= r_taken_cnt + CNT_ONE;
    end
  end

  assign pc_f        = r_pc;
  assign pcplus4_f   = r_pc + PC_INCR;
  assign flush_d     = w_redirect;
  assign fetch_valid = r_fetch_valid;
  assign halt        = r_halt;
  assign branch_cnt  = r_branch_cnt;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (RESET_PC=0x0040_0000, CNT_W=4).
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_f, stall_d;
  logic        branch_d, eq_d, jump_d, jr_d;
  logic [31:0] pcplus4_d, signimm_d, rs_d;
  logic [25:0] instr_idx_d;
  logic [31:0] pc_f, pcplus4_f;
  logic        flush_d, fetch_valid, halt;
  logic [3:0]  branch_cnt, taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(
    .RESET_PC (32'h0040_0000),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .branch_d    (branch_d),
    .eq_d        (eq_d),
    .jump_d      (jump_d),
    .jr_d        (jr_d),
    .pcplus4_d   (pcplus4_d),
    .signimm_d   (signimm_d),
    .rs_d        (rs_d),
    .instr_idx_d (instr_idx_d),
    .pc_f        (pc_f),
    .pcplus4_f   (pcplus4_f),
    .flush_d     (flush_d),
    .fetch_valid (fetch_valid),
    .halt        (halt),
    .branch_cnt  (branch_cnt),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_f = 0; stall_d = 0; branch_d = 0; eq_d = 0; jump_d = 0; jr_d = 0;
    pcplus4_d = '0; signimm_d = '0; rs_d = '0; instr_idx_d = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    // Redirect request during reset must not show up.
    jump_d = 1; pcplus4_d = 32'h1000_0000; instr_idx_d = 26'h3;
    #12;
    check("rst_pc",    pc_f,               32'h0040_0000);
    check("rst_fv",    32'(fetch_valid),   32'd0);
    check("rst_halt",  32'(halt),          32'd0);
    check("rst_flush", 32'(flush_d),       32'd0);
    check("rst_bcnt",  32'(branch_cnt),    32'd0);
    check("rst_tcnt",  32'(taken_cnt),     32'd0);
    idle_inputs();

    // Reset release: one BOOT cycle, then sequential fetch.
    @(posedge clk); #1 reset = 1'b0;
    check("boot_fv",  32'(fetch_valid), 32'd0);
    check("boot_pc",  pc_f,             32'h0040_0000);
    tick();
    check("run_fv",   32'(fetch_valid), 32'd1);
    check("seq_pc0",  pc_f,             32'h0040_0000);
    tick();
    check("seq_pc1",  pc_f,             32'h0040_0004);
    tick();
    check("seq_pc2",  pc_f,             32'h0040_0008);
    check("seq_pc4f", pcplus4_f,        32'h0040_000C);

    // Taken beq with negative offset.
    branch_d = 1; eq_d = 1; pcplus4_d = 32'h0000_0104; signimm_d = 32'hFFFF_FFFE;
    #1 check("beq_flush", 32'(flush_d), 32'd1);
    tick();
    check("beq_pc",   pc_f,            32'h0000_00FC);
    check("beq_tcnt", 32'(taken_cnt),  32'd1);
    check("beq_bcnt", 32'(branch_cnt), 32'd1);
    idle_inputs();

    // Jump wins over concurrent taken branch and over a fetch stall.
    jump_d = 1; branch_d = 1; eq_d = 1; stall_f = 1;
    pcplus4_d = 32'hA000_0010; instr_idx_d = 26'h0000_100; signimm_d = 32'h0000_0040;
    #1 check("j_flush", 32'(flush_d), 32'd1);
    tick();
    check("j_pc",   pc_f,            32'hA000_0400);
    check("j_bcnt", 32'(branch_cnt), 32'd2);
    check("j_tcnt", 32'(taken_cnt),  32'd1);
    idle_inputs();

    // Fetch stall holds the PC.
    stall_f = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stallf_pc", pc_f, 32'hA000_0400);
    end
    // Decode stall blocks the redirect and counting.
    stall_d = 1; branch_d = 1; eq_d = 1; pcplus4_d = 32'h0000_0200;
    #1 check("stalld_flush", 32'(flush_d), 32'd0);
    tick();
    check("stalld_bcnt", 32'(branch_cnt), 32'd2);
    check("stalld_tcnt", 32'(taken_cnt),  32'd1);
    check("stalld_pc",   pc_f,            32'hA000_0400);
    idle_inputs();

    // 20 taken branches saturate both 4-bit counters.
    branch_d = 1; eq_d = 1; pcplus4_d = 32'h0000_0100; signimm_d = 32'h0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_bcnt", 32'(branch_cnt), 32'hF);
    check("sat_tcnt", 32'(taken_cnt),  32'hF);
    check("sat_pc",   pc_f,            32'h0000_0100);
    idle_inputs();

    // PC wrap at the top of the address space.
    jr_d = 1; rs_d = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    check("wrap_pre",   pc_f,      32'hFFFF_FFFC);
    check("wrap_pc4f",  pcplus4_f, 32'h0000_0000);
    tick();
    check("wrap_pc",    pc_f,      32'h0000_0000);

    // Misaligned jr; pc_f is 0 entering this cycle.
    stall_f = 1; // keep pc_f parked at 0 while idle
    #1;
    stall_f = 0; jr_d = 1; rs_d = 32'h0000_1002;
    #1 check("jr_flush", 32'(flush_d), 32'd1);
    tick();
    idle_inputs();
`ifdef PC_MISALIGN_TRAP_EN
    check("trap_halt", 32'(halt),        32'd1);
    check("trap_fv",   32'(fetch_valid), 32'd0);
    check("trap_pc",   pc_f,             32'h0000_0000);
    branch_d = 1; eq_d = 1; pcplus4_d = 32'h0000_0800;
    #1 check("halt_flush", 32'(flush_d), 32'd0);
    tick(); tick();
    check("halt_pc",   pc_f,            32'h0000_0000);
    check("halt_stay", 32'(halt),       32'd1);
    check("halt_bcnt", 32'(branch_cnt), 32'hF);
    idle_inputs();
`else
    check("jr_pc",   pc_f,             32'h0000_1000);
    check("jr_halt", 32'(halt),        32'd0);
    check("jr_fv",   32'(fetch_valid), 32'd1);
`endif

    // Reset asserted in the middle of a redirect discards it.
    jump_d = 1; pcplus4_d = 32'h5000_0000; instr_idx_d = 26'h10;
    #1 reset = 1'b1;
    #1;
    check("midrst_pc",    pc_f,            32'h0040_0000);
    check("midrst_flush", 32'(flush_d),    32'd0);
    check("midrst_bcnt",  32'(branch_cnt), 32'd0);
    check("midrst_halt",  32'(halt),       32'd0);
    tick();
    check("midrst_hold",  pc_f,            32'h0040_0000);
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_fv",  32'(fetch_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
